// File: rtl/tb_rst_seq_wdog.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_wdog
//
// Bench-infrastructure block. After the bench reset releases, it holds N_CH
// reset channels low for RST_DLY cycles. It then releases them one at a time,
// in ascending index order, every RST_STEP cycles. Once all channels are out
// of reset, a kickable cycle-count watchdog runs. When the watchdog expires it
// raises a sticky flag and a one-cycle pulse. If WDOG_RST_EN is set, it also
// re-runs the whole reset sequence.
//
// Cycle numbering: cycle n is the value held after n clock edges that see
// neither rst_n low nor sw_rst_req high. Channel i is therefore first seen
// high in cycle RST_DLY + i*RST_STEP.
//
// Ports
//   clk                 in   1       bench clock
//   rst_n               in   1       synchronous active-low reset
//   sw_rst_req          in   1       restart the reset sequence (pulse or level)
//   wdog_en             in   1       watchdog count enable
//   wdog_kick           in   1       clear watchdog count (wins over enable)
//   ch_rst_n            out  N_CH    generated active-low resets, bit i = channel i
//   all_released        out  1       every ch_rst_n bit is high
//   seq_busy            out  1       sequencer is holding or releasing
//   wdog_cnt            out  WDOG_W  current watchdog count
//   wdog_timeout        out  1       sticky timeout flag
//   wdog_timeout_pulse  out  1       one-cycle pulse on timeout entry
// ---------------------------------------------------------------------------
module tb_rst_seq_wdog #(
  parameter int          N_CH         = 4,
  parameter int          CNT_W        = 16,
  parameter int          RST_DLY      = 100,
  parameter int          RST_STEP     = 10,
  parameter int          WDOG_W       = 32,
  parameter int unsigned WDOG_TIMEOUT = 1000000,
  parameter bit          WDOG_RST_EN  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_rst_req,
  input  logic              wdog_en,
  input  logic              wdog_kick,
  output logic [N_CH-1:0]   ch_rst_n,
  output logic              all_released,
  output logic              seq_busy,
  output logic [WDOG_W-1:0] wdog_cnt,
  output logic              wdog_timeout,
  output logic              wdog_timeout_pulse
);

  // Elaboration-time parameter checks.
  if (RST_DLY < 1 || N_CH < 1 || WDOG_TIMEOUT < 1) begin : g_chk_min
    $fatal(1, "tb_rst_seq_wdog: RST_DLY, N_CH and WDOG_TIMEOUT must be >= 1");
  end
  if (64'(RST_DLY) >= (64'd1 << CNT_W) || 64'(RST_STEP) >= (64'd1 << CNT_W)) begin : g_chk_cnt
    $fatal(1, "tb_rst_seq_wdog: RST_DLY and RST_STEP must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RST_DLY - 1);
  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'((RST_STEP == 0) ? 0 : RST_STEP - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_TIMEOUT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [N_CH-1:0]    ch_rst_n_q, ch_rst_n_d;
  logic               all_released_q, all_released_d;
  logic               seq_busy_q, seq_busy_d;
  logic [WDOG_W-1:0]  wdog_cnt_q, wdog_cnt_d;
  logic               wdog_timeout_q, wdog_timeout_d;
  logic               wdog_pulse_q, wdog_pulse_d;

  // Shared decode used by both combinational processes.
  logic            hold_done;
  logic            step_done;
  logic            wdog_fire;
  logic [N_CH-1:0] ch_step;
  logic            release_last;

  assign hold_done = (hold_cnt_q == HOLD_LAST);
  assign step_done = (step_cnt_q == STEP_LAST);
  assign wdog_fire = wdog_en && !wdog_kick && (wdog_cnt_q == WDOG_LAST);

  // Channel pattern after the next release step. The pattern is a
  // thermometer code, so releasing the next channel means shifting in a one.
  // With RST_STEP=0, every channel leaves HOLD together.
  always_comb begin
    if (state_q == S_HOLD) begin
      ch_step = (RST_STEP == 0) ? '1 : N_CH'(1);
    end else begin
      ch_step = (ch_rst_n_q << 1) | N_CH'(1);
    end
  end
  assign release_last = &ch_step;

  // State register. All outputs are registered here as well.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_HOLD;
      hold_cnt_q     <= '0;
      step_cnt_q     <= '0;
      ch_rst_n_q     <= '0;
      all_released_q <= 1'b0;
      seq_busy_q     <= 1'b1;
      wdog_cnt_q     <= '0;
      wdog_timeout_q <= 1'b0;
      wdog_pulse_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      step_cnt_q     <= step_cnt_d;
      ch_rst_n_q     <= ch_rst_n_d;
      all_released_q <= all_released_d;
      seq_busy_q     <= seq_busy_d;
      wdog_cnt_q     <= wdog_cnt_d;
      wdog_timeout_q <= wdog_timeout_d;
      wdog_pulse_q   <= wdog_pulse_d;
    end
  end

  // Next-state logic. sw_rst_req overrides every other transition.
  // NOTE: assigning a default before any branch keeps this block purely
  // combinational; a path that left state_d unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    if (sw_rst_req) begin
      state_d = S_HOLD;
    end else begin
      unique case (state_q)
        S_HOLD:    if (hold_done) state_d = release_last ? S_RUN : S_RELEASE;
        S_RELEASE: if (step_done && release_last) state_d = S_RUN;
        S_RUN:     if (wdog_fire) state_d = S_TIMEOUT;
        S_TIMEOUT: if (WDOG_RST_EN) state_d = S_HOLD;
        default:   state_d = S_HOLD;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    hold_cnt_d     = hold_cnt_q;
    step_cnt_d     = step_cnt_q;
    ch_rst_n_d     = ch_rst_n_q;
    wdog_cnt_d     = wdog_cnt_q;
    wdog_timeout_d = wdog_timeout_q;
    wdog_pulse_d   = 1'b0;

    if (sw_rst_req) begin
      hold_cnt_d     = '0;
      step_cnt_d     = '0;
      ch_rst_n_d     = '0;
      wdog_cnt_d     = '0;
      wdog_timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          wdog_cnt_d = '0;
          if (hold_done) begin
            ch_rst_n_d = ch_step;
            hold_cnt_d = '0;
            step_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          wdog_cnt_d = '0;
          if (step_done) begin
            ch_rst_n_d = ch_step;
            step_cnt_d = '0;
          end else begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (wdog_kick) begin
            wdog_cnt_d = '0;
          end else if (wdog_en) begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
            if (wdog_fire) begin
              wdog_timeout_d = 1'b1;
              wdog_pulse_d   = 1'b1;
            end
          end
        end
        S_TIMEOUT: begin
          // The count stays frozen unless WDOG_RST_EN restarts the sequence.
          // The sticky flag survives that restart.
          if (WDOG_RST_EN) begin
            hold_cnt_d = '0;
            step_cnt_d = '0;
            ch_rst_n_d = '0;
            wdog_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end

    all_released_d = &ch_rst_n_d;
    seq_busy_d     = (state_d == S_HOLD) || (state_d == S_RELEASE);
  end

  assign ch_rst_n           = ch_rst_n_q;
  assign all_released       = all_released_q;
  assign seq_busy           = seq_busy_q;
  assign wdog_cnt           = wdog_cnt_q;
  assign wdog_timeout       = wdog_timeout_q;
  assign wdog_timeout_pulse = wdog_pulse_q;

endmodule

// File: tb/tb_tb_rst_seq_wdog.sv
// ---------------------------------------------------------------------------
// tb_tb_rst_seq_wdog
//
// Two instances share one stimulus stream:
//   dut_a: staggered release (RST_DLY=20, RST_STEP=5), timeout 50, and
//          re-sequencing on timeout.
//   dut_b: single-cycle hold (RST_DLY=1), all channels together, timeout 45,
//          and a sticky TIMEOUT state.
// On every rising edge, a behavioural model advances by one cycle and pushes
// the expected outputs into a per-instance queue. On every falling edge, a
// separate monitor pops one entry and compares it with the DUT outputs.
// The model tracks the sequence as "cycles since restart". It derives channel
// i from n >= RST_DLY + i*RST_STEP.
// ---------------------------------------------------------------------------
module tb_tb_rst_seq_wdog;

  localparam int NCH        = 4;
  localparam int DLY [2]    = '{20, 1};
  localparam int STP [2]    = '{5, 0};
  localparam int TMO [2]    = '{50, 45};
  localparam bit REN [2]    = '{1'b1, 1'b0};

  typedef enum {P_SEQ, P_RUN, P_TMO} phase_e;

  typedef struct packed {
    logic [NCH-1:0] ch;
    logic           all_rel;
    logic           busy;
    logic           to;
    logic           pulse;
    logic [31:0]    cnt;
  } obs_t;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic sw_rst_req = 1'b0;
  logic wdog_en    = 1'b0;
  logic wdog_kick  = 1'b0;

  logic [NCH-1:0] ch_a, ch_b;
  logic           all_a, all_b, busy_a, busy_b, to_a, to_b, pl_a, pl_b;
  logic [31:0]    cnt_a;
  logic [15:0]    cnt_b;

  int total = 0;
  int bad   = 0;

  phase_e m_phase [2];
  int     m_n     [2];
  longint m_cnt   [2];
  bit     m_to    [2];
  bit     m_pulse [2];

  obs_t exp_a [$];
  obs_t exp_b [$];

  tb_rst_seq_wdog #(
    .N_CH(NCH), .CNT_W(8), .RST_DLY(20), .RST_STEP(5),
    .WDOG_W(32), .WDOG_TIMEOUT(50), .WDOG_RST_EN(1'b1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
    .wdog_en(wdog_en), .wdog_kick(wdog_kick),
    .ch_rst_n(ch_a), .all_released(all_a), .seq_busy(busy_a),
    .wdog_cnt(cnt_a), .wdog_timeout(to_a), .wdog_timeout_pulse(pl_a)
  );

  tb_rst_seq_wdog #(
    .N_CH(NCH), .CNT_W(4), .RST_DLY(1), .RST_STEP(0),
    .WDOG_W(16), .WDOG_TIMEOUT(45), .WDOG_RST_EN(1'b0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
    .wdog_en(wdog_en), .wdog_kick(wdog_kick),
    .ch_rst_n(ch_b), .all_released(all_b), .seq_busy(busy_b),
    .wdog_cnt(cnt_b), .wdog_timeout(to_b), .wdog_timeout_pulse(pl_b)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_step(input int id, input logic r, input logic s,
                            input logic e, input logic k);
    m_pulse[id] = 1'b0;
    if (!r || s) begin
      m_phase[id] = P_SEQ;
      m_n[id]     = 0;
      m_cnt[id]   = 0;
      m_to[id]    = 1'b0;
    end else begin
      case (m_phase[id])
        P_SEQ: begin
          m_n[id] = m_n[id] + 1;
          if (m_n[id] >= DLY[id] + (NCH - 1) * STP[id]) m_phase[id] = P_RUN;
        end
        P_RUN: begin
          if (k) begin
            m_cnt[id] = 0;
          end else if (e) begin
            m_cnt[id] = m_cnt[id] + 1;
            if (m_cnt[id] == TMO[id]) begin
              m_to[id]    = 1'b1;
              m_pulse[id] = 1'b1;
              m_phase[id] = P_TMO;
            end
          end
        end
        default: begin
          if (REN[id]) begin
            m_phase[id] = P_SEQ;
            m_n[id]     = 0;
            m_cnt[id]   = 0;
          end
        end
      endcase
    end
  endtask

  function automatic obs_t model_out(input int id);
    obs_t o;
    for (int i = 0; i < NCH; i++) begin
      o.ch[i] = (m_phase[id] == P_SEQ) ? (m_n[id] >= DLY[id] + i * STP[id]) : 1'b1;
    end
    o.all_rel = &o.ch;
    o.busy    = (m_phase[id] == P_SEQ);
    o.to      = m_to[id];
    o.pulse   = m_pulse[id];
    o.cnt     = 32'(m_cnt[id]);
    return o;
  endfunction

  initial begin
    logic r, s, e, k;
    forever begin
      @(posedge clk);
      r = rst_n; s = sw_rst_req; e = wdog_en; k = wdog_kick;
      model_step(0, r, s, e, k);
      model_step(1, r, s, e, k);
      exp_a.push_back(model_out(0));
      exp_b.push_back(model_out(1));
    end
  end

  // ---------------- monitor / comparison ----------------
  task automatic check(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got ch=%b rel=%b busy=%b to=%b pulse=%b cnt=%0d, want ch=%b rel=%b busy=%b to=%b pulse=%b cnt=%0d",
               name, $time, act.ch, act.all_rel, act.busy, act.to, act.pulse, act.cnt,
               exp.ch, exp.all_rel, exp.busy, exp.to, exp.pulse, exp.cnt);
    end
  endtask

  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check("dut_a", {ch_a, all_a, busy_a, to_a, pl_a, cnt_a}, e);
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check("dut_b", {ch_b, all_b, busy_b, to_b, pl_b, {16'd0, cnt_b}}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic s, input logic e, input logic k, input int n);
    repeat (n) begin
      @(negedge clk);
      sw_rst_req = s;
      wdog_en    = e;
      wdog_kick  = k;
    end
  endtask

  initial begin
    // Power-on: reset for 5 edges, then let both sequences complete.
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 60);

    // Kick every 40 cycles with the watchdog enabled: no timeout.
    for (int i = 0; i < 13; i++) begin
      drive(0, 1, 1, 1);
      drive(0, 1, 0, 39);
    end

    // Stop kicking: both instances time out. dut_a re-sequences.
    drive(0, 1, 0, 150);

    // sw_rst_req mid-release, after channels 0 and 1 are out of reset.
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 27);
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 60);

    // sw_rst_req held for several cycles.
    drive(1, 1, 1, 6);
    drive(0, 0, 0, 40);

    // sw_rst_req + kick on the cycle dut_a's timeout would fire.
    drive(0, 1, 1, 1);
    drive(0, 1, 0, 49);
    drive(1, 1, 1, 1);
    drive(0, 0, 0, 10);

    // Same collision at dut_b's timeout.
    drive(0, 1, 1, 1);
    drive(0, 1, 0, 44);
    drive(1, 1, 1, 1);
    drive(0, 0, 0, 10);

    // Randomised traffic, including occasional bench resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n      = ($urandom_range(0, 499) != 0);
      sw_rst_req = ($urandom_range(0, 199) == 0);
      wdog_en    = ($urandom_range(0, 9) != 0);
      wdog_kick  = ($urandom_range(0, 69) == 0);
    end
    @(negedge clk);
    rst_n = 1'b1; sw_rst_req = 1'b0; wdog_en = 1'b0; wdog_kick = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL time_limit: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "time limit");
  end

endmodule
